// File: rtl/density_targeter.sv
// density_targeter: probability-density shot selector; done pulses 2*N*N+2 cycles after the accepted start, start is ignored while busy.
// Optional macro HIT_WEIGHT_EN: hit cells stop blocking and any placement covering a hit scores HIT_WEIGHT.
module density_targeter #(
  parameter int                     BOARD_DIM  = 10,
  parameter int                     NUM_SHIPS  = 5,
  parameter logic [4*NUM_SHIPS-1:0] SHIP_LENS  = 20'h54332,
  parameter int                     DENS_W     = 8,
  parameter int                     HIT_WEIGHT = 4
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic [BOARD_DIM*BOARD_DIM-1:0]             fired,
  input  logic [BOARD_DIM*BOARD_DIM-1:0]             hits,
  input  logic [NUM_SHIPS-1:0]                       ships_alive,
  output logic                                       busy,
  output logic                                       done,
  output logic [$clog2(BOARD_DIM*BOARD_DIM)-1:0]     target_idx,
  output logic [DENS_W-1:0]                          target_density,
  output logic                                       found
);

  localparam int N     = BOARD_DIM;
  localparam int CELLS = N * N;
  localparam int IDX_W = $clog2(CELLS);
  localparam int INC_W = DENS_W + 8;
  localparam int MAXL  = 15;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(CELLS - 1);
  localparam logic [INC_W:0]   DMAX = {{(INC_W + 1 - DENS_W){1'b0}}, {DENS_W{1'b1}}};

  typedef enum logic [2:0] {IDLE, CLEAR, SCAN, SELECT, FINISH} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [IDX_W-1:0]    r_p;
  logic [IDX_W-1:0]    r_best_idx;
  logic [DENS_W-1:0]   r_best_d;
  logic                r_any;
  logic [CELLS-1:0]    r_fired;
  logic [CELLS-1:0]    r_block;
  logic [NUM_SHIPS-1:0] r_alive;
  logic [DENS_W-1:0]   r_dens [CELLS];
  logic                r_done;
  logic [IDX_W-1:0]    r_tidx;
  logic [DENS_W-1:0]   r_tdens;
  logic                r_found;
  logic [INC_W-1:0]    w_inc [CELLS];
  logic [CELLS-1:0]    w_block_in;
  logic [CELLS-1:0]    w_hitmask;
  logic                w_last;

`ifdef HIT_WEIGHT_EN
  logic [CELLS-1:0] r_hits;

  assign w_block_in = fired & ~hits;
  assign w_hitmask  = r_hits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hits <= '0;
    end else if (r_state == IDLE && start) begin
      r_hits <= hits;
    end
  end
`else
  logic w_unused_hits;

  assign w_block_in    = fired;
  assign w_hitmask     = '0;
  assign w_unused_hits = ^hits;
`endif

  assign w_last         = (r_p == LAST);
  assign busy           = (r_state != IDLE);
  assign done           = r_done;
  assign target_idx     = r_tidx;
  assign target_density = r_tdens;
  assign found          = r_found;

  function automatic logic [DENS_W-1:0] f_sat(input logic [DENS_W-1:0] d, input logic [INC_W-1:0] inc);
    logic [INC_W:0] s;
    s = {{(INC_W + 1 - DENS_W){1'b0}}, d} + {1'b0, inc};
    return (s > DMAX) ? DMAX[DENS_W-1:0] : s[DENS_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = CLEAR;
      CLEAR:   w_next = SCAN;
      SCAN:    if (w_last) w_next = SELECT;
      SELECT:  if (w_last) w_next = FINISH;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Per-anchor increments: every alive ship, both orientations, anchored at r_p.
  always_comb begin
    int pi, px, py, len;
    logic h_ok, v_ok, h_hit, v_hit;
    logic [INC_W-1:0] wh, wv;
    for (int c = 0; c < CELLS; c++) w_inc[c] = '0;
    pi = int'(r_p);
    px = pi % N;
    py = pi / N;
    len = 0;
    h_ok = 1'b0; v_ok = 1'b0; h_hit = 1'b0; v_hit = 1'b0;
    wh = '0; wv = '0;
    if (r_state == SCAN) begin
      for (int s = 0; s < NUM_SHIPS; s++) begin
        len   = int'(SHIP_LENS[4*s +: 4]);
        h_ok  = r_alive[s] && (len > 0) && (px + len <= N);
        v_ok  = r_alive[s] && (len > 0) && (py + len <= N);
        h_hit = 1'b0;
        v_hit = 1'b0;
        for (int k = 0; k < MAXL; k++) begin
          if (k < len) begin
            if (h_ok) begin
              h_hit = h_hit | w_hitmask[IDX_W'(pi + k)];
              if (r_block[IDX_W'(pi + k)]) h_ok = 1'b0;
            end
            if (v_ok) begin
              v_hit = v_hit | w_hitmask[IDX_W'(pi + k*N)];
              if (r_block[IDX_W'(pi + k*N)]) v_ok = 1'b0;
            end
          end
        end
        wh = h_hit ? INC_W'(HIT_WEIGHT) : INC_W'(1);
        wv = v_hit ? INC_W'(HIT_WEIGHT) : INC_W'(1);
        for (int k = 0; k < MAXL; k++) begin
          if (k < len) begin
            if (h_ok) w_inc[IDX_W'(pi + k)]   = w_inc[IDX_W'(pi + k)] + wh;
            if (v_ok) w_inc[IDX_W'(pi + k*N)] = w_inc[IDX_W'(pi + k*N)] + wv;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p        <= '0;
      r_best_idx <= '0;
      r_best_d   <= '0;
      r_any      <= 1'b0;
      r_fired    <= '0;
      r_block    <= '0;
      r_alive    <= '0;
      r_done     <= 1'b0;
      r_tidx     <= '0;
      r_tdens    <= '0;
      r_found    <= 1'b0;
      for (int c = 0; c < CELLS; c++) r_dens[c] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_fired <= fired;
            r_block <= w_block_in;
            r_alive <= ships_alive;
          end
        end
        CLEAR: begin
          for (int c = 0; c < CELLS; c++) r_dens[c] <= '0;
          r_p <= '0;
        end
        SCAN: begin
          for (int c = 0; c < CELLS; c++) r_dens[c] <= f_sat(r_dens[c], w_inc[c]);
          r_p <= w_last ? '0 : r_p + 1'b1;
          if (w_last) begin
            r_best_idx <= '0;
            r_best_d   <= '0;
            r_any      <= 1'b0;
          end
        end
        SELECT: begin
          // Strict compare keeps the lowest index on ties; first unfired cell always seeds the best.
          if (!r_fired[r_p] && (!r_any || (r_dens[r_p] > r_best_d))) begin
            r_best_idx <= r_p;
            r_best_d   <= r_dens[r_p];
            r_any      <= 1'b1;
          end
          if (!w_last) r_p <= r_p + 1'b1;
        end
        FINISH: begin
          r_tidx  <= r_best_idx;
          r_tdens <= r_best_d;
          r_found <= (r_best_d != '0);
          r_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_density_targeter.sv
// Bench for density_targeter: table vectors, hand-written start/reset sequences and random boards against a placement-enumeration model.
module tb_density_targeter;

  localparam int N  = 10;
  localparam int C  = N * N;
  localparam int NS = 5;
  localparam int HW = 4;
`ifdef HIT_WEIGHT_EN
  localparam bit HWE = 1'b1;
`else
  localparam bit HWE = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [C-1:0]  fired;
  logic [C-1:0]  hits;
  logic [NS-1:0] ships_alive;
  logic          busy, done, found;
  logic [6:0]    target_idx;
  logic [7:0]    target_density;
  logic          busy_s, done_s, found_s;
  logic [6:0]    target_idx_s;
  logic [4:0]    target_density_s;

  int n_chk;
  int n_fail;

  density_targeter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fired(fired), .hits(hits),
    .ships_alive(ships_alive), .busy(busy), .done(done), .target_idx(target_idx),
    .target_density(target_density), .found(found)
  );

  density_targeter #(.DENS_W(5)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .fired(fired), .hits(hits),
    .ships_alive(ships_alive), .busy(busy_s), .done(done_s), .target_idx(target_idx_s),
    .target_density(target_density_s), .found(found_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no end required end");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Enumerate every placement on the board directly, then pick the best unfired cell.
  function automatic void model(input logic [C-1:0] f, input logic [C-1:0] h, input logic [NS-1:0] a,
                                input int dw, output int e_idx, output int e_d, output int e_found);
    int dens[C];
    int lens[NS];
    logic [C-1:0] blk;
    int x, y, w, cap;
    bit legal, hit, any;
    lens = '{2, 3, 3, 4, 5};
    for (int c = 0; c < C; c++) dens[c] = 0;
    blk = HWE ? (f & ~h) : f;
    for (int s = 0; s < NS; s++) begin
      if (a[s]) begin
        for (int o = 0; o < 2; o++) begin
          for (int y0 = 0; y0 < N; y0++) begin
            for (int x0 = 0; x0 < N; x0++) begin
              legal = 1'b1;
              hit   = 1'b0;
              for (int k = 0; k < lens[s]; k++) begin
                x = x0 + ((o == 0) ? k : 0);
                y = y0 + ((o == 1) ? k : 0);
                if (x >= N || y >= N) legal = 1'b0;
                else begin
                  if (blk[y*N + x]) legal = 1'b0;
                  if (h[y*N + x]) hit = 1'b1;
                end
              end
              if (legal) begin
                w = (HWE && hit) ? HW : 1;
                for (int k = 0; k < lens[s]; k++) begin
                  x = x0 + ((o == 0) ? k : 0);
                  y = y0 + ((o == 1) ? k : 0);
                  dens[y*N + x] += w;
                end
              end
            end
          end
        end
      end
    end
    cap = (1 << dw) - 1;
    e_idx = 0;
    e_d   = 0;
    any   = 1'b0;
    for (int c = 0; c < C; c++) begin
      if (dens[c] > cap) dens[c] = cap;
      if (!f[c] && (!any || dens[c] > e_d)) begin
        e_idx = c;
        e_d   = dens[c];
        any   = 1'b1;
      end
    end
    e_found = (e_d != 0) ? 1 : 0;
  endfunction

  task automatic run_eval(input logic [C-1:0] f, input logic [C-1:0] h, input logic [NS-1:0] a, output int lat);
    int busy_bad;
    logic [127:0] junk;
    busy_bad = 0;
    lat = 0;
    @(negedge clk);
    fired = f; hits = h; ships_alive = a; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    junk = {$urandom, $urandom, $urandom, $urandom};
    fired = junk[C-1:0];
    hits = ~junk[C-1:0];
    ships_alive = junk[NS-1:0];
    for (int i = 1; i <= 1000; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
      if (!busy) busy_bad++;
    end
    chk("busy_low_during_run", busy_bad, 0);
    chk("busy_at_done", int'(busy), 0);
    chk("done_sat_instance", int'(done_s), 1);
  endtask

  typedef struct {
    logic [C-1:0]  f;
    logic [C-1:0]  h;
    logic [NS-1:0] a;
    int            e_idx;
    int            e_d;
    int            e_found;
  } vec_t;

  vec_t tv[6];

  initial begin
    logic [C-1:0] v;
    logic [127:0] r1, r2, r3;
    int lat, e_idx, e_d, e_found, seen;

    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    start = 1'b0;
    fired = '0;
    hits = '0;
    ships_alive = '0;

    tv[0] = '{f: '0, h: '0, a: 5'b11111, e_idx: 44, e_d: 34, e_found: 1};
    v = '1; v[0] = 1'b0; v[1] = 1'b0;
    tv[1] = '{f: v, h: '0, a: 5'b00001, e_idx: 0, e_d: 1, e_found: 1};
    v = '1; v[0] = 1'b0;
    tv[2] = '{f: v, h: '0, a: 5'b11111, e_idx: 0, e_d: 0, e_found: 0};
    v = '0; v[44] = 1'b1;
`ifdef HIT_WEIGHT_EN
    tv[3] = '{f: v, h: v, a: 5'b00001, e_idx: 34, e_d: 7, e_found: 1};
`else
    tv[3] = '{f: v, h: v, a: 5'b00001, e_idx: 11, e_d: 4, e_found: 1};
`endif
    tv[4] = '{f: '1, h: '0, a: 5'b11111, e_idx: 0, e_d: 0, e_found: 0};
    v = '0; v[0] = 1'b1; v[1] = 1'b1; v[2] = 1'b1;
    tv[5] = '{f: v, h: '0, a: 5'b00000, e_idx: 3, e_d: 0, e_found: 0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_target_idx", int'(target_idx), 0);
    chk("reset_target_density", int'(target_density), 0);
    chk("reset_found", int'(found), 0);
    chk("reset_dens0", int'(dut.r_dens[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 6; t++) begin
      run_eval(tv[t].f, tv[t].h, tv[t].a, lat);
      chk($sformatf("vec%0d_latency", t), lat, 202);
      chk($sformatf("vec%0d_target_idx", t), int'(target_idx), tv[t].e_idx);
      chk($sformatf("vec%0d_target_density", t), int'(target_density), tv[t].e_d);
      chk($sformatf("vec%0d_found", t), int'(found), tv[t].e_found);
      model(tv[t].f, tv[t].h, tv[t].a, 5, e_idx, e_d, e_found);
      chk($sformatf("vec%0d_sat_idx", t), int'(target_idx_s), e_idx);
      chk($sformatf("vec%0d_sat_density", t), int'(target_density_s), e_d);
      chk($sformatf("vec%0d_sat_found", t), int'(found_s), e_found);
      if (t == 0) chk("vec0_dens_cell0", int'(dut.r_dens[0]), 10);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("hold_done_low", int'(done), 0);
    chk("hold_target_idx", int'(target_idx), 3);

    // start re-pulsed mid-run with a fully fired board must be ignored
    @(negedge clk);
    fired = '0; hits = '0; ships_alive = '1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 1000; i++) begin
      @(posedge clk);
      #1;
      if (i == 50) begin start = 1'b1; fired = '1; end
      if (i == 51) start = 1'b0;
      if (done) begin lat = i; break; end
    end
    chk("restart_latency", lat, 202);
    chk("restart_target_idx", int'(target_idx), 44);
    chk("restart_target_density", int'(target_density), 34);

    // reset in the middle of a run aborts it
    @(negedge clk);
    fired = '0; ships_alive = '1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (120) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_target_idx", int'(target_idx), 0);
    chk("abort_target_density", int'(target_density), 0);
    chk("abort_found", int'(found), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    chk("abort_no_done", seen, 0);
    run_eval('0, '0, 5'b11111, lat);
    chk("after_abort_latency", lat, 202);
    chk("after_abort_target_idx", int'(target_idx), 44);
    chk("after_abort_found", int'(found), 1);

    for (int it = 0; it < 20; it++) begin
      logic [C-1:0] rf, rh;
      logic [NS-1:0] ra;
      r1 = {$urandom, $urandom, $urandom, $urandom};
      r2 = {$urandom, $urandom, $urandom, $urandom};
      r3 = {$urandom, $urandom, $urandom, $urandom};
      rf = (it % 2 == 0) ? (r1[C-1:0] & r2[C-1:0]) : (r1[C-1:0] | r2[C-1:0]);
      rh = rf & r3[C-1:0];
      ra = NS'($urandom_range(0, 31));
      run_eval(rf, rh, ra, lat);
      chk($sformatf("rnd%0d_latency", it), lat, 202);
      model(rf, rh, ra, 8, e_idx, e_d, e_found);
      chk($sformatf("rnd%0d_target_idx", it), int'(target_idx), e_idx);
      chk($sformatf("rnd%0d_target_density", it), int'(target_density), e_d);
      chk($sformatf("rnd%0d_found", it), int'(found), e_found);
      model(rf, rh, ra, 5, e_idx, e_d, e_found);
      chk($sformatf("rnd%0d_sat_idx", it), int'(target_idx_s), e_idx);
      chk($sformatf("rnd%0d_sat_density", it), int'(target_density_s), e_d);
      chk($sformatf("rnd%0d_sat_found", it), int'(found_s), e_found);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
